// File: rtl/chsh_trial_tally.sv
// Per-setting agree/total tally for CHSH trial events with a request/ack readout
// port, a four-cycle sequential clear, and an optional trial limit.
module chsh_trial_tally #(
   parameter int CNT_W       = 32,
   parameter int TRIAL_LIMIT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trial_valid,
   output logic             trial_ready,
   input  logic             trial_x,
   input  logic             trial_y,
   input  logic             trial_a,
   input  logic             trial_b,
   input  logic             freeze,
   input  logic             clear_req,
   output logic             clear_done,
   input  logic             rd_req,
   input  logic [1:0]       rd_setting,
   output logic             rd_ack,
   output logic [CNT_W-1:0] rd_agree,
   output logic [CNT_W-1:0] rd_total,
   output logic [CNT_W-1:0] total_trials,
   output logic             sat_flag,
   output logic             busy
);

   typedef enum logic [1:0] {ST_RUN, ST_CLEAR, ST_LIMIT} state_t;

   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(TRIAL_LIMIT);

   state_t           state, state_nxt;
   logic [1:0]       clr_cnt;
   logic [CNT_W-1:0] agree_mem [4];
   logic [CNT_W-1:0] total_mem [4];
   logic             pend_vld;

   logic             accept;
   logic             agree_hit;
   logic [1:0]       idx;
   logic             clr_go;
   logic             clr_last;
   logic             sat_hit;
   logic [CNT_W-1:0] total_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign trial_ready = (state == ST_RUN) & ~freeze & ~rst;
   assign busy        = (state == ST_CLEAR);
   assign accept      = trial_valid & trial_ready;
   assign idx         = {trial_x, trial_y};
   assign agree_hit   = accept & (trial_a == trial_b);
   assign clr_go      = clear_req & (state != ST_CLEAR);
   assign clr_last    = (state == ST_CLEAR) & (clr_cnt == 2'd3);
   assign total_inc   = sat_inc(total_trials);
   // A counter already at all-ones that is incremented again would have wrapped.
   assign sat_hit     = accept & ((&total_mem[idx]) | (agree_hit & (&agree_mem[idx])) |
                                  (&total_trials));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (clr_go)
               state_nxt = ST_CLEAR;
            else if ((TRIAL_LIMIT != 0) && accept && (total_inc == LIMIT_V))
               state_nxt = ST_LIMIT;
         end
         ST_LIMIT: if (clear_req) state_nxt = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == 2'd3) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_RUN;
         clr_cnt      <= 2'd0;
         clear_done   <= 1'b0;
         total_trials <= '0;
         sat_flag     <= 1'b0;
      end else begin
         state      <= state_nxt;
         clr_cnt    <= (state == ST_CLEAR) ? clr_cnt + 2'd1 : 2'd0;
         clear_done <= clr_last;
         if (clr_go) begin
            total_trials <= '0;
            sat_flag     <= 1'b0;
         end else begin
            if (accept)  total_trials <= total_inc;
            if (sat_hit) sat_flag     <= 1'b1;
         end
      end
   end

   // Counter array: trial updates in RUN, one entry wiped per CLEAR cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            agree_mem[i] <= '0;
            total_mem[i] <= '0;
         end
      end else if (state == ST_CLEAR) begin
         agree_mem[clr_cnt] <= '0;
         total_mem[clr_cnt] <= '0;
      end else if (accept) begin
         total_mem[idx] <= sat_inc(total_mem[idx]);
         if (agree_hit) agree_mem[idx] <= sat_inc(agree_mem[idx]);
      end
   end

   // Readout stage: request cycle -> ack cycle. A read parked across a clear
   // always sees wiped entries, so only its presence needs remembering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_vld <= 1'b0;
         rd_ack   <= 1'b0;
         rd_agree <= '0;
         rd_total <= '0;
      end else begin
         rd_ack <= 1'b0;
         if (clr_last) begin
            if (pend_vld | rd_req) begin
               rd_ack   <= 1'b1;
               rd_agree <= '0;
               rd_total <= '0;
            end
            pend_vld <= 1'b0;
         end else if (rd_req & ((state == ST_CLEAR) | clr_go)) begin
            pend_vld <= 1'b1;
         end else if (rd_req) begin
            rd_ack   <= 1'b1;
            rd_agree <= agree_mem[rd_setting];
            rd_total <= total_mem[rd_setting];
         end
      end
   end

endmodule

// File: tb/tb_chsh_trial_tally.sv
// Directed bench for chsh_trial_tally: readout data goes through an expectation
// queue drained by a monitor; control outputs are compared inline.
module tb_chsh_trial_tally;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx, ty, ta, tb;

   logic       a_tv, a_ready, a_freeze, a_clr, a_done, a_rd_req, a_rd_ack;
   logic [1:0] a_rd_set;
   logic [3:0] a_rd_agree, a_rd_total, a_total;
   logic       a_sat, a_busy;

   logic       b_tv, b_ready, b_freeze, b_clr, b_done, b_rd_req, b_rd_ack;
   logic [1:0] b_rd_set;
   logic [7:0] b_rd_agree, b_rd_total, b_total;
   logic       b_sat, b_busy;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct packed {
      logic [3:0] agree;
      logic [3:0] total;
      logic       at_done;
   } rd_exp_t;
   rd_exp_t exp_q[$];
   rd_exp_t mon_e;

   always #5 clk = ~clk;

   chsh_trial_tally #(.CNT_W(4), .TRIAL_LIMIT(0)) dut_a (
      .clk(clk), .rst(rst), .trial_valid(a_tv), .trial_ready(a_ready),
      .trial_x(tx), .trial_y(ty), .trial_a(ta), .trial_b(tb),
      .freeze(a_freeze), .clear_req(a_clr), .clear_done(a_done),
      .rd_req(a_rd_req), .rd_setting(a_rd_set), .rd_ack(a_rd_ack),
      .rd_agree(a_rd_agree), .rd_total(a_rd_total), .total_trials(a_total),
      .sat_flag(a_sat), .busy(a_busy));

   chsh_trial_tally #(.CNT_W(8), .TRIAL_LIMIT(3)) dut_b (
      .clk(clk), .rst(rst), .trial_valid(b_tv), .trial_ready(b_ready),
      .trial_x(tx), .trial_y(ty), .trial_a(ta), .trial_b(tb),
      .freeze(b_freeze), .clear_req(b_clr), .clear_done(b_done),
      .rd_req(b_rd_req), .rd_setting(b_rd_set), .rd_ack(b_rd_ack),
      .rd_agree(b_rd_agree), .rd_total(b_rd_total), .total_trials(b_total),
      .sat_flag(b_sat), .busy(b_busy));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic trial(input logic x, input logic y, input logic a, input logic b);
      tx = x; ty = y; ta = a; tb = b;
      a_tv = 1'b1;
      tick();
      a_tv = 1'b0;
   endtask

   task automatic rd(input logic [1:0] s, input logic [3:0] agree, input logic [3:0] total);
      a_rd_req = 1'b1;
      a_rd_set = s;
      exp_q.push_back({agree, total, 1'b0});
      tick();
      a_rd_req = 1'b0;
      check("rd_ack_next_cycle", a_rd_ack, 1);
   endtask

   task automatic clear_a();
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("a_busy_in_clear", a_busy, 1);
         tick();
      end
      check("a_clear_done", a_done, 1);
      check("a_busy_after_clear", a_busy, 0);
   endtask

   // Readout monitor
   always @(negedge clk) begin
      if (a_rd_ack) begin
         if (a_busy) check("rd_ack_during_clear", a_busy, 0);
         if (exp_q.size() == 0) begin
            check("rd_ack_unexpected", a_rd_ack, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rd_agree", a_rd_agree, mon_e.agree);
            check("rd_total", a_rd_total, mon_e.total);
            if (mon_e.at_done) check("rd_ack_in_clear_done_cycle", a_done, 1);
         end
      end
   end

   initial begin
      rst = 1'b1;
      {tx, ty, ta, tb} = 4'b0;
      {a_tv, a_freeze, a_clr, a_rd_req} = 4'b0;
      a_rd_set = 2'd0;
      {b_tv, b_freeze, b_clr, b_rd_req} = 4'b0;
      b_rd_set = 2'd0;
      tick();
      tick();
      check("rst_trial_ready", a_ready, 0);
      check("rst_total_trials", a_total, 0);
      check("rst_sat_flag", a_sat, 0);
      check("rst_busy", a_busy, 0);
      check("rst_clear_done", a_done, 0);
      check("rst_rd_ack", a_rd_ack, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", a_ready, 1);
      tick();

      // T1: basic tally and back-to-back reads
      trial(0, 0, 0, 0);
      trial(0, 0, 1, 0);
      trial(1, 1, 1, 1);
      trial(0, 1, 0, 1);
      check("t1_total_trials", a_total, 4);
      check("t1_sat_flag", a_sat, 0);
      rd(2'd0, 4'd1, 4'd2);
      rd(2'd3, 4'd1, 4'd1);
      rd(2'd1, 4'd0, 4'd1);
      tick();
      check("t1_rd_ack_drops", a_rd_ack, 0);
      check("t1_rd_agree_held", a_rd_agree, 0);
      check("t1_rd_total_held", a_rd_total, 1);

      // T4: read issued together with clear is parked until clear_done
      a_clr = 1'b1;
      a_rd_req = 1'b1;
      a_rd_set = 2'd0;
      exp_q.push_back({4'd0, 4'd0, 1'b1});
      tick();
      a_clr = 1'b0;
      a_rd_req = 1'b0;
      check("t4_total_zeroed_on_entry", a_total, 0);
      for (int i = 0; i < 4; i++) begin
         check("t4_busy", a_busy, 1);
         check("t4_no_ack_in_clear", a_rd_ack, 0);
         tick();
      end
      check("t4_clear_done", a_done, 1);
      check("t4_ack_with_done", a_rd_ack, 1);
      tick();
      check("t4_clear_done_pulse", a_done, 0);
      rd(2'd0, 4'd0, 4'd0);
      rd(2'd3, 4'd0, 4'd0);

      // T6: freeze blocks acceptance
      tx = 0; ty = 0; ta = 1; tb = 1;
      a_freeze = 1'b1;
      a_tv = 1'b1;
      #1;
      check("t6_ready_frozen", a_ready, 0);
      tick();
      tick();
      tick();
      check("t6_no_count_frozen", a_total, 0);
      a_freeze = 1'b0;
      #1;
      check("t6_ready_released", a_ready, 1);
      tick();
      a_tv = 1'b0;
      check("t6_total_after_release", a_total, 1);
      rd(2'd0, 4'd1, 4'd1);

      // T2: saturation with CNT_W=4
      clear_a();
      for (int i = 0; i < 15; i++) trial(1, 0, 1, 1);
      check("t2_no_sat_at_15", a_sat, 0);
      trial(1, 0, 1, 1);
      check("t2_sat_flag", a_sat, 1);
      check("t2_total_trials_sat", a_total, 15);
      rd(2'd2, 4'd15, 4'd15);
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      check("t2_sat_cleared", a_sat, 0);
      for (int i = 0; i < 4; i++) tick();
      check("t2_clear_done", a_done, 1);

      // T5: async reset in second CLEAR cycle, with a parked read discarded
      rd(2'd2, 4'd0, 4'd0);
      trial(0, 1, 1, 1);
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      a_rd_req = 1'b1;
      a_rd_set = 2'd1;
      tick();
      a_rd_req = 1'b0;
      check("t5_busy_before_rst", a_busy, 1);
      rst = 1'b1;
      #1;
      check("t5_busy_async", a_busy, 0);
      check("t5_ready_async", a_ready, 0);
      check("t5_total_async", a_total, 0);
      check("t5_rd_total_async", a_rd_total, 0);
      tick();
      rst = 1'b0;
      #1;
      check("t5_ready_after_release", a_ready, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_no_clear_done", a_done, 0);
      end
      check("t5_busy_after_release", a_busy, 0);

      // T3: trial limit of 3 on the second instance
      tx = 0; ty = 0; ta = 0; tb = 1;
      b_tv = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t3_ready_per_cycle", b_ready, (i < 3) ? 1 : 0);
         tick();
      end
      b_tv = 1'b0;
      check("t3_total_trials", b_total, 3);
      b_clr = 1'b1;
      tick();
      b_clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t3_busy", b_busy, 1);
         tick();
      end
      check("t3_clear_done", b_done, 1);
      check("t3_ready_after_clear", b_ready, 1);
      check("t3_b_rd_idle", {b_rd_ack, b_rd_agree, b_rd_total, b_sat}, 0);

      tick();
      check("rd_queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
